// File: rtl/sysid_checker.sv
// System-ID read master: reads the ID and timestamp words after reset
// (or on request) and flags any mismatch against the build-time values.
module sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'h6103_9B7F,
  parameter int          START_DELAY        = 16,
  parameter int          READ_LATENCY       = 0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        recheck,
  output logic        sysid_address,
  output logic        sysid_read,
  input  logic [31:0] sysid_readdata,
  output logic        busy,
  output logic        done,
  output logic        id_match,
  output logic        ts_match,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic [7:0]  fail_count
);

  typedef enum logic [2:0] {
    S_WAIT,
    S_RD_ID,
    S_RD_TS,
    S_CMP,
    S_DONE
  } state_t;

  // A zero delay still spends the first edge leaving WAIT.
  localparam logic [15:0] DLY_LAST =
    (START_DELAY == 0) ? 16'd0 : 16'(START_DELAY - 1);
  localparam logic [2:0] LAT_LAST = 3'(READ_LATENCY);

  state_t      state;
  logic [15:0] dly;
  logic [2:0]  lat;
  logic        id_ok;
  logic        ts_ok;

  assign id_ok = (id_value == EXPECTED_ID);
  assign ts_ok = (ts_value == EXPECTED_TIMESTAMP);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_WAIT;
      dly           <= '0;
      lat           <= '0;
      sysid_address <= 1'b0;
      sysid_read    <= 1'b0;
      busy          <= 1'b1;
      done          <= 1'b0;
      id_match      <= 1'b0;
      ts_match      <= 1'b0;
      id_value      <= '0;
      ts_value      <= '0;
      fail_count    <= '0;
    end else begin
      unique case (state)
        S_WAIT: begin
          if (dly == DLY_LAST) begin
            dly           <= '0;
            state         <= S_RD_ID;
            sysid_read    <= 1'b1;
            sysid_address <= 1'b0;
          end else begin
            dly <= dly + 16'd1;
          end
        end
        S_RD_ID: begin
          if (lat == LAT_LAST) begin
            id_value      <= sysid_readdata;
            lat           <= '0;
            state         <= S_RD_TS;
            sysid_address <= 1'b1;
          end else begin
            lat <= lat + 3'd1;
          end
        end
        S_RD_TS: begin
          if (lat == LAT_LAST) begin
            ts_value      <= sysid_readdata;
            lat           <= '0;
            state         <= S_CMP;
            sysid_read    <= 1'b0;
            sysid_address <= 1'b0;
          end else begin
            lat <= lat + 3'd1;
          end
        end
        S_CMP: begin
          id_match <= id_ok;
          ts_match <= ts_ok;
          if (!(id_ok && ts_ok) && fail_count != 8'hFF)
            fail_count <= fail_count + 8'd1;
          state <= S_DONE;
          done  <= 1'b1;
          busy  <= 1'b0;
        end
        S_DONE: begin
          if (recheck) begin
            state         <= S_RD_ID;
            done          <= 1'b0;
            busy          <= 1'b1;
            id_match      <= 1'b0;
            ts_match      <= 1'b0;
            sysid_read    <= 1'b1;
            sysid_address <= 1'b0;
          end
        end
        default: state <= S_WAIT;
      endcase
    end
  end

endmodule
